// File: rtl/shift_reg_sequencer.sv
// Round-robin arbiter and sequencer that drives an external right-shift register as a
// framed parallel-to-serial transmitter, LSB first, with an idle gap between frames.
module shift_reg_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sr_load,
  output logic [WIDTH-1:0] sr_d,
  output logic             sr_shift_en,
  input  logic             sr_q0,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             owner,
  output logic             busy,
  output logic             done
);

  localparam int unsigned GapCycles = GAP * DIV;
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GapW = (GapCycles > 1) ? $clog2(GapCycles) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GapCycles > 0) ? GapCycles - 1 : 0);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

  state_e          state_q;
  logic [DivW-1:0] div_cnt_q;
  logic [BitW-1:0] bit_cnt_q;
  logic [GapW-1:0] gap_cnt_q;
  logic            last_grant_q;
  logic            owner_q;
  logic [WIDTH-1:0] sr_d_q;

  logic grant0, grant1, div_last, bit_last, in_shift;

  // On a tie the requester that did not win last time gets the register.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant_q);
    grant1 = req1_valid && (!req0_valid || !last_grant_q);
  end

  assign in_shift = (state_q == StShift);
  assign div_last = (div_cnt_q == DivLast);
  assign bit_last = (bit_cnt_q == BitLast);

  assign req0_ready  = !rst && (state_q == StIdle) && grant0;
  assign req1_ready  = !rst && (state_q == StIdle) && grant1;
  assign sr_load     = (state_q == StLoad);
  assign sr_d        = sr_d_q;
  assign sr_shift_en = in_shift && div_last && !bit_last;
  assign done        = in_shift && div_last && bit_last;
  assign ser_valid   = in_shift;
  assign ser_out     = in_shift && sr_q0;
  assign owner       = owner_q;
  assign busy        = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      sr_d_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant0 || grant1) begin
            sr_d_q       <= grant1 ? req1_data : req0_data;
            owner_q      <= grant1;
            last_grant_q <= grant1;
            state_q      <= StLoad;
          end
        end
        StLoad: begin
          div_cnt_q <= '0;
          bit_cnt_q <= '0;
          state_q   <= StShift;
        end
        StShift: begin
          if (div_last) begin
            div_cnt_q <= '0;
            if (bit_last) begin
              gap_cnt_q <= '0;
              state_q   <= (GAP == 0) ? StIdle : StGap;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench: two sequencer instances, each driving a behavioural shift register.
module tb_shift_reg_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  // Instance A: WIDTH=4 DIV=4 GAP=1
  logic       req0_valid = 0, req1_valid = 0;
  logic [3:0] req0_data = 0, req1_data = 0;
  logic       req0_ready, req1_ready, sr_load, sr_shift_en, sr_q0;
  logic       ser_out, ser_valid, owner, busy, done;
  logic [3:0] sr_d, sr_q;

  shift_reg_sequencer #(.WIDTH(4), .DIV(4), .GAP(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .sr_load(sr_load), .sr_d(sr_d), .sr_shift_en(sr_shift_en), .sr_q0(sr_q0),
    .ser_out(ser_out), .ser_valid(ser_valid), .owner(owner), .busy(busy), .done(done)
  );

  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else if (sr_load) sr_q <= sr_d;
    else if (sr_shift_en) sr_q <= {1'b0, sr_q[3:1]};
  end
  assign sr_q0 = sr_q[0];

  // Instance B: WIDTH=4 DIV=1 GAP=0
  logic       b_req0_valid = 0, b_req1_valid = 0;
  logic [3:0] b_req0_data = 0, b_req1_data = 0;
  logic       b_req0_ready, b_req1_ready, b_sr_load, b_sr_shift_en, b_sr_q0;
  logic       b_ser_out, b_ser_valid, b_owner, b_busy, b_done;
  logic [3:0] b_sr_d, b_sr_q;

  shift_reg_sequencer #(.WIDTH(4), .DIV(1), .GAP(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .sr_load(b_sr_load), .sr_d(b_sr_d), .sr_shift_en(b_sr_shift_en), .sr_q0(b_sr_q0),
    .ser_out(b_ser_out), .ser_valid(b_ser_valid), .owner(b_owner), .busy(b_busy),
    .done(b_done)
  );

  always_ff @(posedge clk) begin
    if (rst) b_sr_q <= '0;
    else if (b_sr_load) b_sr_q <= b_sr_d;
    else if (b_sr_shift_en) b_sr_q <= {1'b0, b_sr_q[3:1]};
  end
  assign b_sr_q0 = b_sr_q[0];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; b_req0_valid = 0; b_req1_valid = 0;
    rst = 1;
    step();
    step();
    rst = 0;
    #1;
  endtask

  task automatic wait_grant(output int who);
    who = -1;
    for (int i = 0; i < 40; i++) begin
      if (req0_ready) begin who = 0; break; end
      if (req1_ready) begin who = 1; break; end
      step();
    end
    if (who < 0) check_eq("grant_timeout", 0, 1);
  endtask

  // Entered on the handshake cycle; leaves on the first IDLE cycle after the frame.
  task automatic frame_check(input logic [3:0] word, input logic exp_owner,
                             input logic n0v, input logic [3:0] n0d,
                             input logic n1v, input logic [3:0] n1d);
    int busy_cycles;
    busy_cycles = 0;
    step();
    req0_valid = n0v; req0_data = n0d; req1_valid = n1v; req1_data = n1d;
    #1;
    check_eq("load", sr_load, 1);
    check_eq("load_d", sr_d, word);
    check_eq("owner", owner, exp_owner);
    check_eq("load_ready", {req0_ready, req1_ready}, 0);
    if (busy) busy_cycles++;
    for (int c = 1; c <= 16; c++) begin
      step();
      check_eq("shift_valid", ser_valid, 1);
      check_eq("shift_bit", ser_out, word[(c-1)/4]);
      check_eq("shift_en", sr_shift_en, (c % 4 == 0) && (c != 16));
      check_eq("shift_done", done, c == 16);
      check_eq("shift_ctl", {sr_load, req0_ready, req1_ready}, 0);
      if (busy) busy_cycles++;
    end
    for (int g = 1; g <= 4; g++) begin
      step();
      check_eq("gap_out", {ser_valid, ser_out, sr_shift_en, sr_load, done}, 0);
      if (busy) busy_cycles++;
    end
    step();
    check_eq("idle_busy", busy, 0);
    check_eq("busy_cycles", busy_cycles, 21);
  endtask

  initial begin
    int who;
    int last_cyc;
    logic [3:0] words [4];
    words[0] = 4'h3; words[1] = 4'hC; words[2] = 4'h9; words[3] = 4'h0;

    // Reset with both requesters valid
    req0_valid = 1; req0_data = 4'hA; req1_valid = 1; req1_data = 4'h5;
    step();
    step();
    check_eq("rst_ready", {req0_ready, req1_ready}, 0);
    check_eq("rst_busy", busy, 0);
    rst = 0;
    #1;
    check_eq("post_rst_ready", {req0_ready, req1_ready}, 2'b10);
    check_eq("post_rst_idle", {busy, sr_load, ser_valid, done, owner}, 0);
    check_eq("post_rst_sr_d", sr_d, 0);
    do_reset();

    // Single frame from req0
    req0_valid = 1; req0_data = 4'b1011;
    #1;
    wait_grant(who);
    check_eq("t2_grant", who, 0);
    frame_check(4'b1011, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    do_reset();

    // Both continuously valid: alternating grants on a 22-cycle period
    req0_valid = 1; req0_data = 4'hA; req1_valid = 1; req1_data = 4'h5;
    #1;
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(who);
      check_eq("rr_grant", who, k % 2);
      if (k > 0) check_eq("rr_period", cyc - last_cyc, 22);
      last_cyc = cyc;
      frame_check((k % 2) ? 4'h5 : 4'hA, k[0], 1'b1, 4'hA, 1'b1, 4'h5);
    end
    do_reset();

    // Only req1: three back-to-back frames
    req1_valid = 1; req1_data = words[0];
    #1;
    for (int k = 0; k < 3; k++) begin
      wait_grant(who);
      check_eq("r1_grant", who, 1);
      check_eq("r1_immediate", busy, 0);
      frame_check(words[k], 1'b1, 1'b0, 4'h0, k < 2, words[k+1]);
    end
    do_reset();

    // Reset mid-frame at bit_cnt == 2
    req1_valid = 1; req1_data = 4'h6;
    #1;
    wait_grant(who);
    check_eq("abort_grant", who, 1);
    step();
    for (int c = 1; c <= 10; c++) begin
      step();
      check_eq("abort_nodone", done, 0);
    end
    check_eq("abort_bit2", ser_out, 1);
    rst = 1;
    step();
    check_eq("abort_idle", {busy, ser_valid, done, sr_load, sr_shift_en}, 0);
    check_eq("abort_rst_ready", {req0_ready, req1_ready}, 0);
    rst = 0;
    #1;
    check_eq("abort_owner", owner, 0);
    check_eq("abort_sr_clear", sr_q, 0);
    check_eq("abort_reaccept", {req0_ready, req1_ready}, 2'b01);
    frame_check(4'h6, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    do_reset();

    // DIV=1 GAP=0 instance
    b_req0_valid = 1; b_req0_data = 4'b0110;
    #1;
    check_eq("b_ready", b_req0_ready, 1);
    step();
    b_req0_data = 4'b1001;
    #1;
    check_eq("b_load", {b_sr_load, b_sr_d}, {1'b1, 4'b0110});
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq("b_valid", b_ser_valid, 1);
      check_eq("b_bit", b_ser_out, (c == 1) || (c == 2));
      check_eq("b_done", b_done, c == 3);
      check_eq("b_shift_en", b_sr_shift_en, c != 3);
    end
    step();
    check_eq("b_next_ready", b_req0_ready, 1);
    check_eq("b_idle", {b_busy, b_ser_valid}, 0);
    b_req0_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
Name: shift_reg_sequencer

Overview:
Controller that shares one external WIDTH-bit right-shift register between two requesters and sequences it as a parallel-to-serial transmitter. Arbitrates two valid/ready word sources round-robin, drives the register's load/shift_en/d controls, paces shifts with a clock divider, and presents the register LSB as a framed serial stream with an inter-frame gap.

Parameters:
WIDTH, 4, word width; matches the shift register width (>=2)
DIV, 4, clock cycles per serial bit (>=1)
GAP, 1, idle bit-times after each frame (>=0)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset; also drives the shift register's rst
req0_valid  in  1  requester 0 has a word
req0_data  in  WIDTH  requester 0 word
req0_ready  out  1  requester 0 word accepted this cycle
req1_valid  in  1  requester 1 has a word
req1_data  in  WIDTH  requester 1 word
req1_ready  out  1  requester 1 word accepted this cycle
sr_load  out  1  to shift register load
sr_d  out  WIDTH  to shift register d
sr_shift_en  out  1  to shift register shift_en
sr_q0  in  1  shift register q[0]
ser_out  out  1  serial data (ser_out = sr_q0 in SHIFT, else 0)
ser_valid  out  1  high in every SHIFT-state cycle
owner  out  1  requester whose word is in flight
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on last cycle of frame

Behaviour:
- Reset: state IDLE; sr_load, sr_shift_en, ser_out, ser_valid, busy, done, owner = 0; sr_d = 0; div_cnt, bit_cnt, gap_cnt = 0; last_grant = 1, so req0 wins the first tie. reqN_ready forced 0 while rst is high.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE: grant = the only valid requester; if both are valid, grant the requester != last_grant. reqN_ready = (state==IDLE) & grant_N, combinational, at most one high. On handshake: capture data into sr_d, set owner = last_grant = N, go LOAD. No valid: stay in IDLE.
- Data is sampled only on handshake. A requester must hold valid/data until ready. Dropping valid before grant has no effect.
- LOAD: sr_load = 1 for exactly 1 cycle; sr_d is held stable. Then go SHIFT with div_cnt = bit_cnt = 0.
- SHIFT: ser_valid = 1 and ser_out = sr_q0. div_cnt counts 0..DIV-1.
  - At div_cnt == DIV-1 with bit_cnt < WIDTH-1: sr_shift_en = 1 for that cycle and bit_cnt++. The next bit appears the following cycle.
  - At div_cnt == DIV-1 with bit_cnt == WIDTH-1: done = 1 and no shift. Go GAP, or go IDLE if GAP == 0.
  - SHIFT lasts WIDTH*DIV cycles; bits are sent LSB first; sr_shift_en pulses WIDTH-1 times.
- GAP: ser_out = 0, ser_valid = 0. Lasts GAP*DIV cycles, then IDLE.
- sr_load and sr_shift_en are mutually exclusive and are never asserted in IDLE or GAP.
- Throughput: one frame per 1 + 1 + (WIDTH+GAP)*DIV cycles, handshake cycle included. busy is high for 1 + (WIDTH+GAP)*DIV cycles per frame.
- Reset mid-operation: abort the frame. The next cycle is IDLE with all outputs at reset values. The register clears via shared rst. The aborted word is not retransmitted and no done is issued.
- Counter widths: $clog2 of DIV, WIDTH and GAP*DIV, minimum 1 bit. All counters are bounded by terminal compare, with no wrap past the limit.

Test Plan:
- Reset with both valids high -> readies 0 during rst; after release, busy=0, sr_load=0, ser_valid=0, then req0_ready=1 in the first IDLE cycle.
- WIDTH=4 DIV=4 GAP=1, req0 sends 4'b1011 -> req0_ready 1 cycle; sr_load=1 with sr_d=1011 the next cycle; ser_out=1,1,0,1, each held 4 cycles with ser_valid=1; sr_shift_en on SHIFT cycles 4, 8 and 12 (1-based); done on SHIFT cycle 16; busy high for 21 cycles; owner=0.
- Both requesters continuously valid (req0=4'hA, req1=4'h5) -> grants alternate req0, req1, req0, ... with a 22-cycle accept period; owner tracks the grant; ser_out streams 0,1,0,1 then 1,0,1,0.
- Only req1 valid, 3 words -> three back-to-back frames with owner=1; ready asserted exactly once per frame, in the IDLE cycle.
- rst pulsed during SHIFT at bit_cnt=2 -> next cycle IDLE, ser_valid=0, no done pulse; the pending req1 is then accepted with ready on the first post-reset cycle.
- Instance with DIV=1 GAP=0, word 4'b0110 -> ser_out=0,1,1,0 on 4 consecutive cycles; done on the 4th; next handshake possible on the following cycle.
